// File: rtl/pong_vga_renderer_if.sv
// Position bus from the Pong game logic to the renderer, plus the
// renderer's once-per-frame update strobe back to the game logic.
interface pong_vga_renderer_if;
    logic [9:0] ball_x;
    logic [9:0] ball_y;
    logic [9:0] paddle_y;
    logic       frame_tick;

    modport master (
        output ball_x,
        output ball_y,
        output paddle_y,
        input  frame_tick
    );

    modport slave (
        input  ball_x,
        input  ball_y,
        input  paddle_y,
        output frame_tick
    );
endinterface

// File: rtl/pong_vga_renderer.sv
// VGA timing generator and ball/paddle renderer. Positions are latched once
// per frame at the start of vertical blanking; every pin is registered.
module pong_vga_renderer #(
    parameter int unsigned H_ACTIVE      = 640,
    parameter int unsigned H_FP          = 16,
    parameter int unsigned H_SYNC        = 96,
    parameter int unsigned H_BP          = 48,
    parameter int unsigned V_ACTIVE      = 480,
    parameter int unsigned V_FP          = 10,
    parameter int unsigned V_SYNC        = 2,
    parameter int unsigned V_BP          = 33,
    parameter int unsigned BALL_SIZE     = 10,
    parameter int unsigned PADDLE_WIDTH  = 10,
    parameter int unsigned PADDLE_HEIGHT = 60,
    parameter int unsigned PADDLE_X      = 0
) (
    input  logic               clk,
    input  logic               rst_n,
    pong_vga_renderer_if.slave game,
    output logic               hsync,
    output logic               vsync,
    output logic [1:0]         red,
    output logic [1:0]         green,
    output logic [1:0]         blue,
    output logic               display_on
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_ACT    = 10'(H_ACTIVE);
    localparam logic [9:0] V_ACT    = 10'(V_ACTIVE);
    localparam logic [9:0] SNAP_ROW = 10'(V_ACTIVE - 1);
    localparam logic [9:0] HS_BEG   = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] VS_BEG   = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);

    localparam logic [10:0] BALL_SZ = 11'(BALL_SIZE);
    localparam logic [10:0] PAD_X   = 11'(PADDLE_X);
    localparam logic [10:0] PAD_W   = 11'(PADDLE_WIDTH);
    localparam logic [10:0] PAD_H   = 11'(PADDLE_HEIGHT);

    localparam logic [9:0] BALL_X_RST   = 10'd320;
    localparam logic [9:0] BALL_Y_RST   = 10'd240;
    localparam logic [9:0] PADDLE_Y_RST = 10'd210;

    logic [9:0]  h_cnt_q, h_cnt_d;
    logic [9:0]  v_cnt_q, v_cnt_d;
    logic [9:0]  sbx_q, sbx_d;
    logic [9:0]  sby_q, sby_d;
    logic [9:0]  spy_q, spy_d;
    logic        hsync_q, hsync_d;
    logic        vsync_q, vsync_d;
    logic [1:0]  red_q, red_d;
    logic [1:0]  green_q, green_d;
    logic [1:0]  blue_q, blue_d;
    logic        display_on_q, display_on_d;
    logic        frame_tick_q, frame_tick_d;

    logic        h_wrap_s;
    logic        snap_s;
    logic        active_s;
    logic        ball_hit_s;
    logic        paddle_hit_s;
    logic [10:0] h_ext_s;
    logic [10:0] v_ext_s;

    // Raster position counters and the end-of-visible-frame snapshot point.
    always_comb begin
        h_cnt_d  = h_cnt_q;
        v_cnt_d  = v_cnt_q;
        h_wrap_s = (h_cnt_q == H_LAST);
        snap_s   = h_wrap_s && (v_cnt_q == SNAP_ROW);
        if (h_wrap_s) begin
            h_cnt_d = 10'd0;
            if (v_cnt_q == V_LAST) begin
                v_cnt_d = 10'd0;
            end else begin
                v_cnt_d = v_cnt_q + 10'd1;
            end
        end else begin
            h_cnt_d = h_cnt_q + 10'd1;
            v_cnt_d = v_cnt_q;
        end
    end

    // Position snapshot: the game bus is only looked at on the snapshot cycle.
    always_comb begin
        sbx_d = sbx_q;
        sby_d = sby_q;
        spy_d = spy_q;
        if (snap_s) begin
            sbx_d = game.ball_x;
            sby_d = game.ball_y;
            spy_d = game.paddle_y;
        end else begin
            sbx_d = sbx_q;
            sby_d = sby_q;
            spy_d = spy_q;
        end
    end

    // Hit tests in 11 bits so an edge near 1023 never wraps back to 0. The
    // paddle column test is a single unsigned window compare on h - PAD_X.
    always_comb begin
        h_ext_s      = {1'b0, h_cnt_q};
        v_ext_s      = {1'b0, v_cnt_q};
        active_s     = (h_cnt_q < H_ACT) && (v_cnt_q < V_ACT);
        ball_hit_s   = (h_ext_s >= {1'b0, sbx_q}) &&
                       (h_ext_s <  ({1'b0, sbx_q} + BALL_SZ)) &&
                       (v_ext_s >= {1'b0, sby_q}) &&
                       (v_ext_s <  ({1'b0, sby_q} + BALL_SZ));
        paddle_hit_s = ((h_ext_s - PAD_X) < PAD_W) &&
                       (v_ext_s >= {1'b0, spy_q}) &&
                       (v_ext_s <  ({1'b0, spy_q} + PAD_H));
    end

    // Next pin values: sync windows, blank flag, strobe and colour priority.
    always_comb begin
        hsync_d      = ~((h_cnt_q >= HS_BEG) && (h_cnt_q < HS_END));
        vsync_d      = ~((v_cnt_q >= VS_BEG) && (v_cnt_q < VS_END));
        display_on_d = active_s;
        frame_tick_d = snap_s;
        red_d        = 2'd0;
        green_d      = 2'd0;
        blue_d       = 2'd0;
        if (!active_s) begin
            red_d   = 2'd0;
            green_d = 2'd0;
            blue_d  = 2'd0;
        end else if (ball_hit_s) begin
            red_d   = 2'd3;
            green_d = 2'd3;
            blue_d  = 2'd3;
        end else if (paddle_hit_s) begin
            red_d   = 2'd0;
            green_d = 2'd3;
            blue_d  = 2'd0;
        end else begin
            red_d   = 2'd0;
            green_d = 2'd0;
            blue_d  = 2'd0;
        end
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            h_cnt_q      <= 10'd0;
            v_cnt_q      <= 10'd0;
            sbx_q        <= BALL_X_RST;
            sby_q        <= BALL_Y_RST;
            spy_q        <= PADDLE_Y_RST;
            hsync_q      <= 1'b1;
            vsync_q      <= 1'b1;
            red_q        <= 2'd0;
            green_q      <= 2'd0;
            blue_q       <= 2'd0;
            display_on_q <= 1'b0;
            frame_tick_q <= 1'b0;
        end else begin
            h_cnt_q      <= h_cnt_d;
            v_cnt_q      <= v_cnt_d;
            sbx_q        <= sbx_d;
            sby_q        <= sby_d;
            spy_q        <= spy_d;
            hsync_q      <= hsync_d;
            vsync_q      <= vsync_d;
            red_q        <= red_d;
            green_q      <= green_d;
            blue_q       <= blue_d;
            display_on_q <= display_on_d;
            frame_tick_q <= frame_tick_d;
        end
    end

    assign hsync           = hsync_q;
    assign vsync           = vsync_q;
    assign red             = red_q;
    assign green           = green_q;
    assign blue            = blue_q;
    assign display_on      = display_on_q;
    assign game.frame_tick = frame_tick_q;

endmodule

// File: tb/tb_pong_vga_renderer.sv
// Bench for pong_vga_renderer: a shrunk-timing instance for whole-frame
// scenarios and a full 640x480 instance for the first lines of real timing.
module tb_pong_vga_renderer;

    localparam int S_HA = 64, S_HFP = 4, S_HS = 8, S_HBP = 4;
    localparam int S_VA = 48, S_VFP = 2, S_VS = 2, S_VBP = 3;
    localparam int S_BS = 4, S_PW = 3, S_PH = 12, S_PX = 2;
    localparam int S_HT = S_HA + S_HFP + S_HS + S_HBP;
    localparam int S_VT = S_VA + S_VFP + S_VS + S_VBP;
    localparam int S_FRAME = S_HT * S_VT;

    localparam int F_HA = 640, F_HFP = 16, F_HS = 96, F_HBP = 48;
    localparam int F_VA = 480, F_VFP = 10, F_VS = 2, F_VBP = 33;
    localparam int F_BS = 10, F_PW = 10, F_PH = 60, F_PX = 0;
    localparam int F_HT = F_HA + F_HFP + F_HS + F_HBP;
    localparam int F_VT = F_VA + F_VFP + F_VS + F_VBP;

    localparam logic [9:0] RESET_PINS = 10'b11_0000_0000;

    logic       clk;
    logic       rst_n;
    logic [9:0] bx_v, by_v, py_v;

    logic       s_hsync, s_vsync, s_disp;
    logic [1:0] s_red, s_green, s_blue;
    logic       f_hsync, f_vsync, f_disp;
    logic [1:0] f_red, f_green, f_blue;
    logic [9:0] pins_s, pins_f;

    int tests = 0;
    int fails = 0;

    int t_s, t_f;
    int sbx, sby, spy, fbx, fby, fpy;
    int pix_h, pix_v, fpix_h, fpix_v;
    logic [9:0] exp_s, exp_f;

    pong_vga_renderer_if game_s ();
    pong_vga_renderer_if game_f ();

    assign game_s.ball_x   = bx_v;
    assign game_s.ball_y   = by_v;
    assign game_s.paddle_y = py_v;
    assign game_f.ball_x   = bx_v;
    assign game_f.ball_y   = by_v;
    assign game_f.paddle_y = py_v;

    pong_vga_renderer #(
        .H_ACTIVE(S_HA), .H_FP(S_HFP), .H_SYNC(S_HS), .H_BP(S_HBP),
        .V_ACTIVE(S_VA), .V_FP(S_VFP), .V_SYNC(S_VS), .V_BP(S_VBP),
        .BALL_SIZE(S_BS), .PADDLE_WIDTH(S_PW), .PADDLE_HEIGHT(S_PH), .PADDLE_X(S_PX)
    ) dut (
        .clk(clk), .rst_n(rst_n), .game(game_s.slave),
        .hsync(s_hsync), .vsync(s_vsync), .red(s_red), .green(s_green),
        .blue(s_blue), .display_on(s_disp)
    );

    pong_vga_renderer dut_full (
        .clk(clk), .rst_n(rst_n), .game(game_f.slave),
        .hsync(f_hsync), .vsync(f_vsync), .red(f_red), .green(f_green),
        .blue(f_blue), .display_on(f_disp)
    );

    assign pins_s = {s_hsync, s_vsync, s_red, s_green, s_blue, s_disp, game_s.frame_tick};
    assign pins_f = {f_hsync, f_vsync, f_red, f_green, f_blue, f_disp, game_f.frame_tick};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference picture: what the pins should show for raster position (h,v).
    function automatic logic [8:0] model_pins(input bit full, input int h, input int v,
                                              input int bx, input int by, input int py);
        int ha, va, hs0, hs1, vs0, vs1, bs, px, pw, ph;
        bit act, ball, pad;
        logic [5:0] rgb;
        if (full) begin
            ha = F_HA; va = F_VA; hs0 = F_HA + F_HFP; hs1 = hs0 + F_HS;
            vs0 = F_VA + F_VFP; vs1 = vs0 + F_VS; bs = F_BS; px = F_PX; pw = F_PW; ph = F_PH;
        end else begin
            ha = S_HA; va = S_VA; hs0 = S_HA + S_HFP; hs1 = hs0 + S_HS;
            vs0 = S_VA + S_VFP; vs1 = vs0 + S_VS; bs = S_BS; px = S_PX; pw = S_PW; ph = S_PH;
        end
        act  = (h < ha) && (v < va);
        ball = (h >= bx) && (h < bx + bs) && (v >= by) && (v < by + bs);
        pad  = (h >= px) && (h < px + pw) && (v >= py) && (v < py + ph);
        if (!act)      rgb = 6'b00_00_00;
        else if (ball) rgb = 6'b11_11_11;
        else if (pad)  rgb = 6'b00_11_00;
        else           rgb = 6'b00_00_00;
        return {!((h >= hs0) && (h < hs1)), !((v >= vs0) && (v < vs1)), rgb, act};
    endfunction

    // One clock: predict both instances' pins from the pre-edge position.
    task automatic tick();
        bit rst_now;
        int h, v, fh, fv;
        rst_now = rst_n;
        h  = t_s % S_HT;  v  = (t_s / S_HT) % S_VT;
        fh = t_f % F_HT;  fv = (t_f / F_HT) % F_VT;
        if (!rst_now) begin
            exp_s = RESET_PINS; exp_f = RESET_PINS;
            sbx = 320; sby = 240; spy = 210;
            fbx = 320; fby = 240; fpy = 210;
        end else begin
            exp_s = {model_pins(1'b0, h, v, sbx, sby, spy), (h == S_HT - 1) && (v == S_VA - 1)};
            if ((h == S_HT - 1) && (v == S_VA - 1)) begin
                sbx = bx_v; sby = by_v; spy = py_v;
            end
            exp_f = {model_pins(1'b1, fh, fv, fbx, fby, fpy), (fh == F_HT - 1) && (fv == F_VA - 1)};
            if ((fh == F_HT - 1) && (fv == F_VA - 1)) begin
                fbx = bx_v; fby = by_v; fpy = py_v;
            end
        end
        pix_h = h; pix_v = v; fpix_h = fh; fpix_v = fv;
        @(posedge clk);
        #1;
        t_s = rst_now ? t_s + 1 : 0;
        t_f = rst_now ? t_f + 1 : 0;
    endtask

    task automatic wait_tick(output bit found);
        found = 1'b0;
        for (int i = 0; i < 2 * S_FRAME; i++) begin
            tick();
            if (game_s.frame_tick === 1'b1) begin
                found = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bx_v = 10'($urandom); by_v = 10'($urandom); py_v = 10'($urandom);
            tick();
            tests++;
            if (pins_s !== RESET_PINS) begin
                fails++; $display("FAIL reset_small: got %b expected %b", pins_s, RESET_PINS);
            end
            tests++;
            if (pins_f !== RESET_PINS) begin
                fails++; $display("FAIL reset_full: got %b expected %b", pins_f, RESET_PINS);
            end
        end
        rst_n = 1'b1;
    endtask

    task automatic test_full_line();
        int hs_low = 0, first_low = -1, disp = 0;
        for (int i = 0; i < 2 * F_HT + 10; i++) begin
            tick();
            tests++;
            if (pins_f !== exp_f) begin
                fails++; $display("FAIL full_pins at (%0d,%0d): got %b expected %b", fpix_h, fpix_v, pins_f, exp_f);
            end
            if (fpix_v == 0 && f_hsync === 1'b0) begin
                hs_low++;
                if (first_low < 0) first_low = fpix_h;
            end
            if (fpix_v == 0 && f_disp === 1'b1) disp++;
        end
        tests++;
        if (hs_low != 96) begin fails++; $display("FAIL full_hsync_width: got %0d expected 96", hs_low); end
        tests++;
        if (first_low != 656) begin fails++; $display("FAIL full_hsync_start: got %0d expected 656", first_low); end
        tests++;
        if (disp != 640) begin fails++; $display("FAIL full_display_on: got %0d expected 640", disp); end
    endtask

    task automatic test_timing();
        int hs_low = 0, vs_low = 0, nt = 0, first_t = 0, last_t = 0;
        bit found;
        wait_tick(found);
        tests++;
        if (!found) begin fails++; $display("FAIL timing_sync: got no frame_tick expected one"); end
        for (int i = 0; i < 2 * S_FRAME; i++) begin
            bx_v = 10'($urandom_range(0, 70)); by_v = 10'($urandom_range(0, 55));
            py_v = 10'($urandom_range(0, 55));
            tick();
            tests++;
            if (pins_s !== exp_s) begin
                fails++; $display("FAIL timing_pins at (%0d,%0d): got %b expected %b", pix_h, pix_v, pins_s, exp_s);
            end
            if (s_hsync === 1'b0) hs_low++;
            if (s_vsync === 1'b0) vs_low++;
            if (game_s.frame_tick === 1'b1) begin
                nt++;
                if (nt == 1) first_t = i;
                last_t = i;
            end
        end
        tests++;
        if (hs_low != 2 * S_VT * S_HS) begin fails++; $display("FAIL timing_hsync_count: got %0d expected %0d", hs_low, 2 * S_VT * S_HS); end
        tests++;
        if (vs_low != 2 * S_VS * S_HT) begin fails++; $display("FAIL timing_vsync_count: got %0d expected %0d", vs_low, 2 * S_VS * S_HT); end
        tests++;
        if (nt != 2) begin fails++; $display("FAIL timing_tick_count: got %0d expected 2", nt); end
        tests++;
        if (last_t - first_t != S_FRAME) begin fails++; $display("FAIL timing_tick_period: got %0d expected %0d", last_t - first_t, S_FRAME); end
    endtask

    // Runs one whole frame after a snapshot; counts white/green pixels by raster position.
    task automatic run_frame(input string name, input int chg_v, input logic [9:0] chg_x,
                             output int white, output int green, output int min_h,
                             output int min_v, output int blank_col);
        white = 0; green = 0; min_h = 9999; min_v = 9999; blank_col = 0;
        for (int i = 0; i < S_FRAME; i++) begin
            tick();
            if (pix_v == chg_v && pix_h == 0) bx_v = chg_x;
            tests++;
            if (pins_s !== exp_s) begin
                fails++; $display("FAIL %s_pins at (%0d,%0d): got %b expected %b", name, pix_h, pix_v, pins_s, exp_s);
            end
            if (s_red === 2'd3 && s_green === 2'd3 && s_blue === 2'd3) begin
                white++;
                if (pix_h < min_h) min_h = pix_h;
                if (pix_v < min_v) min_v = pix_v;
            end
            if (s_red === 2'd0 && s_green === 2'd3 && s_blue === 2'd0) green++;
            if (s_disp === 1'b0 && {s_red, s_green, s_blue} !== 6'd0) blank_col++;
        end
    endtask

    task automatic test_ball_hold();
        int w, g, mh, mv, bc, x, y;
        bit found;
        x = $urandom_range(0, S_HA - S_BS); y = $urandom_range(0, S_VA - S_BS);
        bx_v = 10'(x); by_v = 10'(y); py_v = 10'd600;
        wait_tick(found);
        tests++;
        if (!found) begin fails++; $display("FAIL ball_sync: got no frame_tick expected one"); end
        run_frame("ball", -1, 10'd0, w, g, mh, mv, bc);
        tests++;
        if (w != S_BS * S_BS) begin fails++; $display("FAIL ball_white_count: got %0d expected %0d", w, S_BS * S_BS); end
        tests++;
        if (mh != x || mv != y) begin fails++; $display("FAIL ball_origin: got (%0d,%0d) expected (%0d,%0d)", mh, mv, x, y); end
    endtask

    task automatic test_paddle();
        int w, g, mh, mv, bc;
        bit found;
        bx_v = 10'($urandom_range(S_HA, 1023)); by_v = 10'($urandom_range(S_VA, 1023)); py_v = 10'd0;
        wait_tick(found);
        tests++;
        if (!found) begin fails++; $display("FAIL paddle_sync: got no frame_tick expected one"); end
        run_frame("paddle", -1, 10'd0, w, g, mh, mv, bc);
        tests++;
        if (g != S_PW * S_PH) begin fails++; $display("FAIL paddle_green_count: got %0d expected %0d", g, S_PW * S_PH); end
        tests++;
        if (w != 0) begin fails++; $display("FAIL paddle_no_white: got %0d expected 0", w); end
    endtask

    task automatic test_overlap();
        int w, g, mh, mv, bc, py;
        bit found;
        py = $urandom_range(0, S_VA - S_PH);
        bx_v = 10'd1; by_v = 10'(py + 2); py_v = 10'(py);
        wait_tick(found);
        tests++;
        if (!found) begin fails++; $display("FAIL overlap_sync: got no frame_tick expected one"); end
        run_frame("overlap", -1, 10'd0, w, g, mh, mv, bc);
        tests++;
        if (w != 16) begin fails++; $display("FAIL overlap_white: got %0d expected 16", w); end
        tests++;
        if (g != 24) begin fails++; $display("FAIL overlap_green: got %0d expected 24", g); end
    endtask

    task automatic test_midframe();
        int w, g, mh, mv, bc, a, b;
        bit found;
        a = $urandom_range(0, 20); b = a + 20 + $urandom_range(0, 20);
        bx_v = 10'(a); by_v = 10'($urandom_range(0, S_VA - S_BS)); py_v = 10'd600;
        wait_tick(found);
        tests++;
        if (!found) begin fails++; $display("FAIL midframe_sync: got no frame_tick expected one"); end
        run_frame("midframe_a", 20, 10'(b), w, g, mh, mv, bc);
        tests++;
        if (mh != a || w != 16) begin fails++; $display("FAIL midframe_current: got col %0d n %0d expected col %0d n 16", mh, w, a); end
        run_frame("midframe_b", -1, 10'd0, w, g, mh, mv, bc);
        tests++;
        if (mh != b || w != 16) begin fails++; $display("FAIL midframe_next: got col %0d n %0d expected col %0d n 16", mh, w, b); end
    endtask

    task automatic test_boundary();
        int w, g, mh, mv, bc;
        bit found;
        bx_v = 10'(S_HA - 3); by_v = 10'(S_VA - 3); py_v = 10'd700;
        wait_tick(found);
        tests++;
        if (!found) begin fails++; $display("FAIL edge_sync: got no frame_tick expected one"); end
        run_frame("edge", -1, 10'd0, w, g, mh, mv, bc);
        tests++;
        if (w != 9) begin fails++; $display("FAIL edge_white_count: got %0d expected 9", w); end
        tests++;
        if (mh != S_HA - 3 || mv != S_VA - 3) begin fails++; $display("FAIL edge_no_wrap: got (%0d,%0d) expected (%0d,%0d)", mh, mv, S_HA - 3, S_VA - 3); end
        tests++;
        if (bc != 0) begin fails++; $display("FAIL edge_blank_rgb: got %0d expected 0", bc); end
    endtask

    task automatic test_reset_midframe();
        int k = -1;
        for (int i = 0; i < 2 * S_FRAME && t_s % S_FRAME != 30 * S_HT + 40; i++) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tests++;
        if (pins_s !== RESET_PINS) begin fails++; $display("FAIL midreset_pins: got %b expected %b", pins_s, RESET_PINS); end
        for (int i = 1; i <= S_FRAME; i++) begin
            tick();
            tests++;
            if (pins_s !== exp_s) begin
                fails++; $display("FAIL midreset_pins at (%0d,%0d): got %b expected %b", pix_h, pix_v, pins_s, exp_s);
            end
            if (game_s.frame_tick === 1'b1) begin k = i; break; end
        end
        tests++;
        if (k != S_VA * S_HT) begin fails++; $display("FAIL midreset_tick_delay: got %0d expected %0d", k, S_VA * S_HT); end
    endtask

    initial begin
        rst_n = 1'b0;
        bx_v = 10'd0; by_v = 10'd0; py_v = 10'd0;
        t_s = 0; t_f = 0;
        test_reset();
        test_full_line();
        test_timing();
        test_ball_hold();
        test_paddle();
        test_overlap();
        test_midframe();
        test_boundary();
        test_reset_midframe();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
